// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: FSM states, ROM word layout,
// note values and control encodings.
package song_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_PLAY,
      ST_GAP,
      ST_DONE
   } state_t;

   // ROM word layout: {end, note[3:0], octave[1:0], dur[3:0]}
   localparam int ROM_W   = 11;
   localparam int END_BIT = 10;
   localparam int NOTE_HI = 9;
   localparam int NOTE_LO = 6;
   localparam int OCT_HI  = 5;
   localparam int OCT_LO  = 4;
   localparam int DUR_HI  = 3;
   localparam int DUR_LO  = 0;

   localparam logic [3:0] REST = 4'd0;
   localparam logic [3:0] DO   = 4'd1;
   localparam logic [3:0] RE   = 4'd2;
   localparam logic [3:0] MI   = 4'd3;
   localparam logic [3:0] FA   = 4'd4;
   localparam logic [3:0] SOL  = 4'd5;
   localparam logic [3:0] LA   = 4'd6;
   localparam logic [3:0] SI   = 4'd7;

   localparam logic [2:0] MODE_AUTO = 3'b010;

   localparam int SEL_NEXT   = 0;
   localparam int SEL_PREV   = 1;
   localparam int SEL_REPLAY = 2;

   // A select request only counts when exactly one of its bits is set.
   function automatic logic single_select(input logic [2:0] sel);
      return (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
   endfunction

endpackage

// File: rtl/song_sequencer_led.sv
// One-hot LED display of the note currently on the buzzer.
module note_led_decode
   import song_sequencer_pkg::*;
(
   input  logic [3:0] note,
   output logic [6:0] led
);

   always_comb begin
      led = '0;
      case (note)
         DO:      led = 7'b0000001;
         RE:      led = 7'b0000010;
         MI:      led = 7'b0000100;
         FA:      led = 7'b0001000;
         SOL:     led = 7'b0010000;
         LA:      led = 7'b0100000;
         SI:      led = 7'b1000000;
         default: led = '0;
      endcase
   end

endmodule

// File: rtl/song_sequencer.sv
// Auto-play song sequencer: walks a song's notes out of an external ROM,
// holding each note for its beat count followed by a short silent gap.
module song_sequencer
   import song_sequencer_pkg::*;
#(
   parameter  int SONG_CNT  = 4,
   parameter  int STEP_W    = 6,
   parameter  int GAP_TICKS = 1,
   localparam int IDX_W     = (SONG_CNT > 1) ? $clog2(SONG_CNT) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [2:0]               song_select,
   input  logic [2:0]               mode,
   input  logic                     beat_tick,
   output logic [IDX_W+STEP_W-1:0]  rom_addr,
   input  logic [ROM_W-1:0]         rom_data,
   output logic [3:0]               note_out,
   output logic [1:0]               octave_out,
   output logic [6:0]               led_out,
   output logic [3:0]               song_num,
   output logic                     busy,
   output logic                     done
);

   localparam int GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
   localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(SONG_CNT - 1);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   song_idx, song_idx_nxt;
   logic [STEP_W-1:0]  step, step_nxt;
   logic [3:0]         dur_cnt, dur_cnt_nxt;
   logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
   logic [3:0]         note_nxt;
   logic [1:0]         octave_nxt;

   logic               sel_valid;
   logic               auto_mode;
   logic               rom_end;
   logic [3:0]         rom_note;
   logic [1:0]         rom_oct;
   logic [3:0]         rom_dur;

   assign rom_end  = rom_data[END_BIT];
   assign rom_note = rom_data[NOTE_HI:NOTE_LO];
   assign rom_oct  = rom_data[OCT_HI:OCT_LO];
   assign rom_dur  = rom_data[DUR_HI:DUR_LO];

   assign sel_valid = single_select(song_select);
   assign auto_mode = (mode == MODE_AUTO);

   assign busy     = (state == ST_FETCH) || (state == ST_LOAD) ||
                     (state == ST_PLAY)  || (state == ST_GAP);
   assign done     = (state == ST_DONE);
   assign rom_addr = {song_idx, step};
   assign song_num = 4'(song_idx);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         song_idx   <= '0;
         step       <= '0;
         dur_cnt    <= '0;
         gap_cnt    <= '0;
         note_out   <= REST;
         octave_out <= '0;
      end else begin
         state      <= state_nxt;
         song_idx   <= song_idx_nxt;
         step       <= step_nxt;
         dur_cnt    <= dur_cnt_nxt;
         gap_cnt    <= gap_cnt_nxt;
         note_out   <= note_nxt;
         octave_out <= octave_nxt;
      end
   end

   // Song selection outranks a mode drop, which outranks normal sequencing.
   always_comb begin
      state_nxt    = state;
      song_idx_nxt = song_idx;
      step_nxt     = step;
      dur_cnt_nxt  = dur_cnt;
      gap_cnt_nxt  = gap_cnt;
      note_nxt     = note_out;
      octave_nxt   = octave_out;

      if (sel_valid && song_select[SEL_NEXT]) begin
         song_idx_nxt = (song_idx == IDX_LAST) ? '0 : song_idx + 1'b1;
         state_nxt    = ST_IDLE;
         note_nxt     = REST;
      end else if (sel_valid && song_select[SEL_PREV]) begin
         song_idx_nxt = (song_idx == '0) ? IDX_LAST : song_idx - 1'b1;
         state_nxt    = ST_IDLE;
         note_nxt     = REST;
      end else if (sel_valid && song_select[SEL_REPLAY] && auto_mode) begin
         step_nxt    = '0;
         dur_cnt_nxt = '0;
         gap_cnt_nxt = '0;
         state_nxt   = ST_FETCH;
         note_nxt    = REST;
      end else if (!auto_mode && busy) begin
         state_nxt = ST_IDLE;
         note_nxt  = REST;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && auto_mode) begin
                  step_nxt  = '0;
                  state_nxt = ST_FETCH;
               end
            end
            ST_FETCH: state_nxt = ST_LOAD;
            ST_LOAD: begin
               if (rom_end || (rom_dur == 4'd0)) begin
                  state_nxt = ST_DONE;
                  note_nxt  = REST;
               end else begin
                  state_nxt   = ST_PLAY;
                  note_nxt    = (rom_note <= SI) ? rom_note : REST;
                  octave_nxt  = rom_oct;
                  dur_cnt_nxt = rom_dur;
               end
            end
            ST_PLAY: begin
               if (beat_tick) begin
                  if (dur_cnt <= 4'd1) begin
                     dur_cnt_nxt = '0;
                     note_nxt    = REST;
                     if (GAP_TICKS == 0) begin
                        if (step == STEP_MAX) begin
                           state_nxt = ST_DONE;
                        end else begin
                           step_nxt  = step + 1'b1;
                           state_nxt = ST_FETCH;
                        end
                     end else begin
                        gap_cnt_nxt = '0;
                        state_nxt   = ST_GAP;
                     end
                  end else begin
                     dur_cnt_nxt = dur_cnt - 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (beat_tick) begin
                  if (gap_cnt == GAP_W'(GAP_LAST)) begin
                     gap_cnt_nxt = '0;
                     if (step == STEP_MAX) begin
                        state_nxt = ST_DONE;
                     end else begin
                        step_nxt  = step + 1'b1;
                        state_nxt = ST_FETCH;
                     end
                  end else begin
                     gap_cnt_nxt = gap_cnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_nxt = ST_IDLE;
               note_nxt  = REST;
            end
            default: begin
               state_nxt = ST_IDLE;
               note_nxt  = REST;
            end
         endcase
      end
   end

   note_led_decode u_led (
      .note (note_out),
      .led  (led_out)
   );

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter SONG_CNT, default 4: number of stored songs, indices 0..SONG_CNT-1.
REQ-002 Parameter STEP_W, default 6: step-index width; each song occupies 2^STEP_W ROM words.
REQ-003 Parameter GAP_TICKS, default 1: silent beat ticks inserted after every note.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse; begins playback of the selected song.
REQ-007 song_select  in  3  single-cycle pulses: [0] next, [1] previous, [2] replay current.
REQ-008 mode  in  3  one-hot; 3'b010 is auto-play, any other value disables the block.
REQ-009 beat_tick  in  1  single-cycle pulse, one per beat unit.
REQ-010 rom_addr  out  log2(SONG_CNT)+STEP_W  = song_idx*2^STEP_W + step.
REQ-011 rom_data  in  11  {end[10], note[9:6], octave[5:4], dur[3:0]}, valid exactly 1 cycle after rom_addr.
REQ-012 note_out  out  4  note to buzzer; 0 = silence, 1..7 = do..si.
REQ-013 octave_out  out  2  octave to buzzer.
REQ-014 led_out  out  7  one-hot note display.
REQ-015 song_num  out  4  current song index, for segment display.
REQ-016 busy  out  1  high in FETCH, LOAD, PLAY, GAP.
REQ-017 done  out  1  single-cycle pulse on entry to DONE.

Function
REQ-018 States: IDLE, FETCH, LOAD, PLAY, GAP, DONE.
REQ-019 IDLE: start with mode==3'b010 -> FETCH, step=0; start otherwise ignored.
REQ-020 FETCH: rom_addr driven from song_idx/step -> LOAD next cycle.
REQ-021 LOAD: capture rom_data; end==1 or dur==0 -> DONE; else -> PLAY with note_out/octave_out updated that edge, dur_cnt=dur.
REQ-022 First note therefore appears on note_out 2 cycles after the start pulse.
REQ-023 PLAY: dur_cnt decrements per beat_tick; tick with dur_cnt==1 -> GAP (GAP_TICKS==0 -> straight to step advance), note_out=0.
REQ-024 GAP: counts GAP_TICKS beat_ticks; then step+1 -> FETCH; step at 2^STEP_W-1 -> DONE instead.
REQ-025 DONE: note_out=0, done pulses once, then -> IDLE next cycle.
REQ-026 Next: song_idx+1, wraps SONG_CNT-1 -> 0; previous: song_idx-1, wraps 0 -> SONG_CNT-1.
REQ-027 Next/previous while busy: update song_idx, note_out=0, -> IDLE (abort, no done pulse).
REQ-028 Replay: step=0, -> FETCH from any state, song_idx unchanged.
REQ-029 Two or more song_select bits high in one cycle: whole select ignored.
REQ-030 start and song_select in same cycle: song_select wins, start ignored.
REQ-031 mode leaving 3'b010 while busy: -> IDLE, note_out=0 next cycle; song_idx kept.
REQ-032 led_out[n-1]=1 for note_out n in 1..7; all zero otherwise.
REQ-033 Note values 8..15 from ROM: played as silence (note_out=0) for their duration.
REQ-034 beat_tick outside PLAY/GAP has no effect.
REQ-035 song_num = song_idx zero-extended to 4 bits.

Reset
REQ-036 reset -> IDLE, song_idx=0, step=0, dur_cnt=0, note_out=0, octave_out=0, led_out=0, busy=0, done=0, rom_addr=0.
REQ-037 reset overrides all other inputs in the same cycle, including mid-note.

Structure
REQ-038 Shared package holds state encoding, ROM word field positions, note constants (REST=0, DO..SI=1..7), mode encodings.
REQ-039 Note-to-LED decoder is a separate sub-module note_led_decode; ROM lives outside this block.

Verification
REQ-040 Song 0 ROM {C,oct1,dur2},{E,oct1,dur1},{end}; start -> note_out 1 after 2 clk, held 2 ticks, 0 for 1 tick, then 3 for 1 tick, done pulse, IDLE.
REQ-041 song_idx=0, previous pulse -> song_num=3; next pulse -> song_num=0.
REQ-042 Mid-note next pulse -> note_out=0 next cycle, IDLE, song_num+1, no done.
REQ-043 mode changed 010->100 during PLAY -> IDLE, note_out=0 next cycle; later start with 100 -> ignored.
REQ-044 reset asserted in GAP -> all outputs reset values next cycle; step restarts at 0 on next start.
REQ-045 next+previous same cycle, and start+next same cycle -> select ignored resp. song advanced with no playback.
